// File: rtl/mux_rr_arb_if.sv
// Bus bundle for mux_rr_arb: N input channels with valid/ready, one output
// channel with valid/ready, the grant index and the arbitration mode.
//
// Handshake: a word moves across a channel on a rising clock edge where its
// valid and ready are both high. A producer holds valid and data steady until
// that transfer happens. Ready on a channel may depend combinationally on the
// valids, but valid never depends on ready.
interface mux_rr_arb_if #(
  parameter int W = 5,
  parameter int N = 4
);
  localparam int CW = $clog2(N);

  logic           MODE;  // 0 = fixed priority, 1 = round-robin
  logic [N*W-1:0] A;     // channel k at A[k*W +: W]
  logic [N-1:0]   AV;
  logic [N-1:0]   AR;
  logic [W-1:0]   Y;
  logic           YV;
  logic           YR;
  logic [CW-1:0]  G;

  // Upstream sources and downstream sink together.
  modport master (
    output MODE, A, AV, YR,
    input  AR, Y, YV, G
  );

  // The arbiter.
  modport slave (
    input  MODE, A, AV, YR,
    output AR, Y, YV, G
  );
endinterface

// File: rtl/mux_rr_arb.sv
// N-to-1 arbitrated multiplexer with a single registered output stage.
// MODE selects fixed priority (lowest index wins) or round-robin starting at
// pointer p_q. A new word is taken only when the output register is empty or
// is being drained in the same cycle, which gives one word per clock.
module mux_rr_arb #(
  parameter int W = 5,
  parameter int N = 4
) (
  input  logic           CLK,
  input  logic           CLRN,
  mux_rr_arb_if.slave    bus,
  output logic           dbg_state  // 1 = FULL, 0 = EMPTY
);
  localparam int CW = $clog2(N);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  y_q, y_d;
  logic [CW-1:0] g_q, g_d;
  logic [CW-1:0] p_q, p_d;

  logic          load;
  logic          win_found;
  logic [CW-1:0] win_idx;
  logic [W-1:0]  win_word;
  logic          accept;
  int            j;

  // Winner search: lowest valid index, or first valid at/after the pointer.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    j         = 0;
    if (!bus.MODE) begin
      // Descending scan so the lowest valid index is written last.
      for (int k = N - 1; k >= 0; k--) begin
        if (bus.AV[k]) begin
          win_found = 1'b1;
          win_idx   = CW'(k);
        end
      end
    end else begin
      // Descending offset so the smallest distance from the pointer wins.
      for (int i = N - 1; i >= 0; i--) begin
        j = (int'(p_q) + i) % N;
        if (bus.AV[j]) begin
          win_found = 1'b1;
          win_idx   = CW'(j);
        end
      end
    end
  end

  // Winner data select; constant-indexed slices keep every width exact.
  always_comb begin
    win_word = '0;
    for (int k = 0; k < N; k++) begin
      if (win_idx == CW'(k)) win_word = bus.A[k*W +: W];
    end
  end

  assign load   = (state_q == ST_EMPTY) | bus.YR;
  // Reset gates the grant so ready stays low while CLRN is held low.
  assign accept = CLRN & load & win_found;

  // One-hot ready to the winning channel, only when a word can be taken.
  always_comb begin
    bus.AR = '0;
    for (int k = 0; k < N; k++) begin
      bus.AR[k] = accept && (win_idx == CW'(k));
    end
  end

  // Output stage next state: load on accept, drain on consume, else hold.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    g_d     = g_q;
    if (accept) begin
      state_d = ST_FULL;
      y_d     = win_word;
      g_d     = win_idx;
    end else if ((state_q == ST_FULL) && bus.YR) begin
      state_d = ST_EMPTY;
    end
  end

  // Round-robin pointer moves past the winner only on round-robin accepts.
  always_comb begin
    p_d = p_q;
    if (accept && bus.MODE) begin
      p_d = (win_idx == CW'(N - 1)) ? '0 : win_idx + CW'(1);
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge CLK or negedge CLRN) begin
    if (!CLRN) begin
      state_q <= ST_EMPTY;
      y_q     <= '0;
      g_q     <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      g_q     <= g_d;
      p_q     <= p_d;
    end
  end

  assign bus.Y     = y_q;
  assign bus.G     = g_q;
  assign bus.YV    = (state_q == ST_FULL);
  assign dbg_state = (state_q == ST_FULL);
endmodule

// File: tb/tb_mux_rr_arb.sv
// Directed bench for mux_rr_arb (W=5, N=4): a vector table walked one clock
// per entry, plus hand-written reset sequences.
module tb_mux_rr_arb;
  localparam int W = 5;
  localparam int N = 4;

  logic clk;
  logic clrn;
  logic dbg_state;

  mux_rr_arb_if #(.W(W), .N(N)) bus ();

  mux_rr_arb #(.W(W), .N(N)) dut (
    .CLK       (clk),
    .CLRN      (clrn),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  typedef struct packed {
    logic         mode;
    logic [3:0]   av;
    logic [19:0]  a;
    logic         yr;
    logic [3:0]   ar;  // expected ready before the edge
    logic [4:0]   y;   // expected after the edge
    logic         yv;
    logic [1:0]   g;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs[NV];

  // Channel words: A1 = {13,12,11,0A}, A2 = {13,12,1F,0A}
  localparam logic [19:0] A1 = {5'h13, 5'h12, 5'h11, 5'h0A};
  localparam logic [19:0] A2 = {5'h13, 5'h12, 5'h1F, 5'h0A};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic mode, input logic [3:0] av, input logic [19:0] a,
                       input logic yr);
    bus.MODE = mode;
    bus.AV   = av;
    bus.A    = a;
    bus.YR   = yr;
  endtask

  // Scoreboard: record the word the granted channel offers.
  task automatic sb_push(input logic [3:0] ar, input logic [19:0] a);
    for (int k = 0; k < N; k++) begin
      if (ar[k]) exp_q.push_back(a[k*W +: W]);
    end
  endtask

  task automatic sb_pop(input string name);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      chk({name, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk(name, {27'd0, bus.Y}, {27'd0, e});
    end
  endtask

  initial begin
    //         mode  av       a   yr  ar       y      yv    g
    vecs[0]  = '{1'b0, 4'b0001, A1, 1'b1, 4'b0001, 5'h0A, 1'b1, 2'd0}; // first accept
    vecs[1]  = '{1'b0, 4'b1110, A1, 1'b1, 4'b0010, 5'h11, 1'b1, 2'd1}; // fixed prio
    vecs[2]  = '{1'b0, 4'b1110, A1, 1'b1, 4'b0010, 5'h11, 1'b1, 2'd1};
    vecs[3]  = '{1'b0, 4'b1110, A1, 1'b1, 4'b0010, 5'h11, 1'b1, 2'd1};
    vecs[4]  = '{1'b1, 4'b1111, A1, 1'b1, 4'b0001, 5'h0A, 1'b1, 2'd0}; // RR from P=0
    vecs[5]  = '{1'b1, 4'b1111, A1, 1'b1, 4'b0010, 5'h11, 1'b1, 2'd1};
    vecs[6]  = '{1'b1, 4'b1111, A1, 1'b1, 4'b0100, 5'h12, 1'b1, 2'd2};
    vecs[7]  = '{1'b1, 4'b1111, A1, 1'b1, 4'b1000, 5'h13, 1'b1, 2'd3};
    vecs[8]  = '{1'b1, 4'b1111, A1, 1'b1, 4'b0001, 5'h0A, 1'b1, 2'd0}; // P -> 1
    vecs[9]  = '{1'b0, 4'b0010, A2, 1'b1, 4'b0010, 5'h1F, 1'b1, 2'd1}; // load 1F
    vecs[10] = '{1'b0, 4'b1111, A2, 1'b0, 4'b0000, 5'h1F, 1'b1, 2'd1}; // stall x4
    vecs[11] = '{1'b0, 4'b1111, A2, 1'b0, 4'b0000, 5'h1F, 1'b1, 2'd1};
    vecs[12] = '{1'b0, 4'b1111, A2, 1'b0, 4'b0000, 5'h1F, 1'b1, 2'd1};
    vecs[13] = '{1'b0, 4'b1111, A2, 1'b0, 4'b0000, 5'h1F, 1'b1, 2'd1};
    vecs[14] = '{1'b0, 4'b0000, A2, 1'b1, 4'b0000, 5'h1F, 1'b0, 2'd1}; // drain, Y holds
    vecs[15] = '{1'b0, 4'b1000, A2, 1'b0, 4'b1000, 5'h13, 1'b1, 2'd3}; // empty accepts ch3
    vecs[16] = '{1'b1, 4'b1111, A2, 1'b1, 4'b0010, 5'h1F, 1'b1, 2'd1}; // RR P=1 kept
    vecs[17] = '{1'b1, 4'b0101, A2, 1'b1, 4'b0100, 5'h12, 1'b1, 2'd2}; // P=2
    vecs[18] = '{1'b1, 4'b0001, A2, 1'b1, 4'b0001, 5'h0A, 1'b1, 2'd0}; // P=3 wraps to 0
    vecs[19] = '{1'b1, 4'b0000, A2, 1'b1, 4'b0000, 5'h0A, 1'b0, 2'd0}; // drain
    vecs[20] = '{1'b0, 4'b0000, A2, 1'b0, 4'b0000, 5'h0A, 1'b0, 2'd0}; // stays empty

    // Reset with busy inputs: everything must be cleared.
    clrn = 1'b0;
    drive(1'b1, 4'b1111, A1, 1'b1);
    #3;
    chk("rst_ar", {28'd0, bus.AR}, 32'd0);
    chk("rst_yv", {31'd0, bus.YV}, 32'd0);
    chk("rst_y",  {27'd0, bus.Y},  32'd0);
    chk("rst_g",  {30'd0, bus.G},  32'd0);
    @(negedge clk);
    @(negedge clk);
    clrn = 1'b1;

    // Table walk: one vector per clock.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].mode, vecs[i].av, vecs[i].a, vecs[i].yr);
      #1;
      chk($sformatf("v%0d_ar", i), {28'd0, bus.AR}, {28'd0, vecs[i].ar});
      sb_push(vecs[i].ar, vecs[i].a);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_yv", i), {31'd0, bus.YV}, {31'd0, vecs[i].yv});
      chk($sformatf("v%0d_y", i),  {27'd0, bus.Y},  {27'd0, vecs[i].y});
      chk($sformatf("v%0d_g", i),  {30'd0, bus.G},  {30'd0, vecs[i].g});
      if (vecs[i].ar != 4'b0000) sb_pop($sformatf("v%0d_sb", i));
      @(negedge clk);
    end

    // Mid-operation reset while FULL and all channels valid.
    drive(1'b1, 4'b1111, A1, 1'b1);
    @(posedge clk);
    #1;
    chk("pre_rst_yv", {31'd0, bus.YV}, 32'd1);
    bus.YR = 1'b0;
    #2;
    clrn = 1'b0;
    #1;
    chk("async_rst_yv", {31'd0, bus.YV}, 32'd0);
    chk("async_rst_ar", {28'd0, bus.AR}, 32'd0);
    chk("async_rst_y",  {27'd0, bus.Y},  32'd0);
    @(negedge clk);
    @(negedge clk);
    clrn = 1'b1;
    #1;
    chk("post_rst_ar", {28'd0, bus.AR}, 32'd1);
    @(posedge clk);
    #1;
    chk("post_rst_g",  {30'd0, bus.G},  32'd0);
    chk("post_rst_yv", {31'd0, bus.YV}, 32'd1);
    chk("post_rst_y",  {27'd0, bus.Y},  32'h0A);
    @(negedge clk);
    // Pointer advanced to 1 after granting channel 0.
    bus.YR = 1'b1;
    #1;
    chk("post_rst_rr_ar", {28'd0, bus.AR}, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
